// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage memory FSM states and address geometry helpers.
package cpu_pkg;

   localparam int ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // Byte-offset bits inside one word, and word-index bits for a given depth
   function automatic int calc_alb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int calc_idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous word storage with per-byte write enables.
// Read-before-write; no reset so the array maps onto block RAM.
module data_memory_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int IDX_W      = 8
) (
   input  logic                    clk,
   input  logic                    rd_en,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rdata <= mem[idx];
      end
      for (int k = 0; k < NB; k++) begin
         if (wr_be[k]) begin
            mem[idx][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/data_memory_sync.sv
// MEM-stage data memory: accepts one request, completes it LATENCY cycles later,
// stalls the pipeline meanwhile and flags misaligned or out-of-range accesses.
module data_memory_sync
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    memread_i,
   input  logic                    memwrite_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    stall_o
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int ALB   = calc_alb(DATA_WIDTH);
   localparam int IDX_W = calc_idx_w(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

   mem_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [NB-1:0]         cap_be;
   logic                  cap_rd;
   logic                  cap_wr;
   logic                  data_zero;

   logic                  req;
   logic                  complete;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [DATA_WIDTH-1:0] op_data;
   logic [NB-1:0]         op_be;
   logic                  op_rd;
   logic                  op_wr;
   logic                  op_err;
   logic [IDX_W-1:0]      op_idx;
   logic                  mem_rd_en;
   logic [NB-1:0]         mem_we;
   logic [DATA_WIDTH-1:0] rd_data;

   // With LATENCY=1 completion happens on the accept edge, so the live inputs
   // are the operands; otherwise the captured request is used.
   always_comb begin
      req      = memread_i | memwrite_i;
      stall_o  = ((state == IDLE) && req) || (state == BUSY);
      complete = ((state == IDLE) && req && (LATENCY == 1)) ||
                 ((state == BUSY) && (cnt == CNT_W'(1)));
      if (state == IDLE) begin
         op_addr = addr_i;
         op_data = data_i;
         op_be   = be_i;
         op_rd   = memread_i;
         op_wr   = memwrite_i;
      end else begin
         op_addr = cap_addr;
         op_data = cap_data;
         op_be   = cap_be;
         op_rd   = cap_rd;
         op_wr   = cap_wr;
      end
      op_err    = ((op_addr & ALIGN_MASK) != '0) || ((op_addr >> (ALB + IDX_W)) != '0);
      op_idx    = op_addr[IDX_W+ALB-1:ALB];
      mem_rd_en = rst_i && complete && op_rd && !op_err;
      mem_we    = (rst_i && complete && op_wr && !op_err) ? op_be : '0;
   end

   data_memory_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk  (clk_i),
      .rd_en(mem_rd_en),
      .wr_be(mem_we),
      .idx  (op_idx),
      .wdata(op_data),
      .rdata(rd_data)
   );

   // The RAM's read register holds its value between reads; data_zero masks
   // it after reset and after an error completion.
   assign data_o = data_zero ? '0 : rd_data;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_addr  <= '0;
         cap_data  <= '0;
         cap_be    <= '0;
         cap_rd    <= 1'b0;
         cap_wr    <= 1'b0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         data_zero <= 1'b1;
      end else begin
         ack_o <= complete;
         err_o <= complete && op_err;
         if (complete) begin
            if (op_err) begin
               data_zero <= 1'b1;
            end else if (op_rd) begin
               data_zero <= 1'b0;
            end
         end
         case (state)
            IDLE: begin
               if (req) begin
                  cap_addr <= addr_i;
                  cap_data <= data_i;
                  cap_be   <= be_i;
                  cap_rd   <= memread_i;
                  cap_wr   <= memwrite_i;
                  if (LATENCY == 1) begin
                     state <= DONE;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: directed vector table, reset-abort
// sequence, randomized traffic against a word-array model, and latency builds 1/2/4.
module tb_data_memory_sync;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memread;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic [31:0] data1, data2, data4;
   logic        ack1, ack2, ack4;
   logic        err1, err2, err4;
   logic        stall1, stall2, stall4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] model[16];
   logic [31:0] lastData;

   always #5 clk = ~clk;

   data_memory_sync #(.DATA_WIDTH(32), .DEPTH(256), .LATENCY(2)) dut2 (
      .clk_i(clk), .rst_i(rst_n), .memread_i(memread), .memwrite_i(memwrite),
      .addr_i(addr), .data_i(wdata), .be_i(be),
      .data_o(data2), .ack_o(ack2), .err_o(err2), .stall_o(stall2));

   data_memory_sync #(.DATA_WIDTH(32), .DEPTH(256), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .memread_i(memread), .memwrite_i(memwrite),
      .addr_i(addr), .data_i(wdata), .be_i(be),
      .data_o(data1), .ack_o(ack1), .err_o(err1), .stall_o(stall1));

   data_memory_sync #(.DATA_WIDTH(32), .DEPTH(256), .LATENCY(4)) dut4 (
      .clk_i(clk), .rst_i(rst_n), .memread_i(memread), .memwrite_i(memwrite),
      .addr_i(addr), .data_i(wdata), .be_i(be),
      .data_o(data4), .ack_o(ack4), .err_o(err4), .stall_o(stall4));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] ed, input logic ee);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.be = b; v.expData = ed; v.expErr = ee;
      vecs.push_back(v);
   endtask

   // One request on the LATENCY=2 instance, held until its ack is seen.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                output logic [31:0] gotData, output logic gotErr, output int lat);
      bit found = 0;
      gotData = '0;
      gotErr  = 1'b0;
      lat     = 0;
      @(negedge clk);
      memread = rd; memwrite = wr; addr = a; wdata = d; be = b;
      #1 checkOutput("stall_on_request", 32'(stall2), 32'd1);
      @(posedge clk);
      for (int k = 1; k <= 10 && !found; k++) begin
         @(negedge clk);
         if (ack2) begin
            found   = 1;
            lat     = k;
            gotData = data2;
            gotErr  = err2;
            checkOutput("stall_low_in_done", 32'(stall2), 32'd0);
         end
      end
      memread = 1'b0; memwrite = 1'b0;
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack_timeout actual=no_ack expected=ack_within_10");
      end
      @(negedge clk);
      checkOutput("ack_one_cycle", 32'(ack2), 32'd0);
   endtask

   initial begin
      logic [31:0] gd;
      logic        ge;
      int          lat;
      int          ackSeen;

      rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_data", data2, 32'h0);
      checkOutput("reset_ack", 32'(ack2), 32'd0);
      checkOutput("reset_err", 32'(err2), 32'd0);
      checkOutput("reset_stall_idle", 32'(stall2), 32'd0);
      memread = 1'b1;
      #1 checkOutput("reset_stall_req", 32'(stall2), 32'd1);
      memread = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      addVec(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h00000000, 0);
      addVec(1, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0);
      addVec(0, 1, 32'h10,  32'h000000AA, 4'h1, 32'hDEADBEEF, 0);
      addVec(1, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 0);
      addVec(1, 0, 32'h12,  32'h0,        4'h0, 32'h00000000, 1);
      addVec(1, 0, 32'h400, 32'h0,        4'h0, 32'h00000000, 1);
      addVec(1, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 0);
      addVec(0, 1, 32'h20,  32'h11111111, 4'hF, 32'hDEADBEAA, 0);
      addVec(1, 1, 32'h20,  32'h22222222, 4'hF, 32'h11111111, 0);
      addVec(1, 0, 32'h20,  32'h0,        4'h0, 32'h22222222, 0);
      addVec(0, 1, 32'h14,  32'h12345678, 4'hF, 32'h22222222, 0);
      addVec(0, 1, 32'h14,  32'hFFFFFFFF, 4'h0, 32'h22222222, 0);
      addVec(1, 0, 32'h14,  32'h0,        4'h0, 32'h12345678, 0);
      addVec(0, 1, 32'h0,   32'h600DF00D, 4'hF, 32'h12345678, 0);
      addVec(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1);
      addVec(1, 0, 32'h0,   32'h0,        4'h0, 32'h600DF00D, 0);
      addVec(0, 1, 32'h32,  32'hFFFFFFFF, 4'hF, 32'h00000000, 1);
      addVec(0, 1, 32'h30,  32'hCAFEF00D, 4'hF, 32'h00000000, 0);
      addVec(1, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, gd, ge, lat);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         checkOutput($sformatf("vec%0d_data", i), gd, vecs[i].expData);
         checkOutput($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].expErr));
      end

      // Reset lands while a write to 0x30 is in BUSY: it must never commit.
      @(negedge clk);
      memwrite = 1'b1; addr = 32'h30; wdata = 32'h55555555; be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; memwrite = 1'b0;
      #1;
      checkOutput("abort_data", data2, 32'h0);
      checkOutput("abort_ack", 32'(ack2), 32'd0);
      checkOutput("abort_stall", 32'(stall2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ackSeen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (ack2) ackSeen++;
      end
      checkOutput("abort_no_ack", 32'(ackSeen), 32'd0);
      checkOutput("abort_err", 32'(err2), 32'd0);
      applyStimulus(1, 0, 32'h30, 32'h0, 4'h0, gd, ge, lat);
      checkOutput("abort_readback", gd, 32'hCAFEF00D);
      checkOutput("abort_readback_err", 32'(ge), 32'd0);
      lastData = 32'hCAFEF00D;

      // Randomized traffic against a plain word-array model of words 0..15.
      for (int w = 0; w < 16; w++) begin
         model[w] = $urandom;
         applyStimulus(0, 1, 32'(w * 4), model[w], 4'hF, gd, ge, lat);
         checkOutput("init_err", 32'(ge), 32'd0);
      end
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a, d, expD;
         logic [3:0]  b;
         logic        rd, wr, isErr;
         int          sel, op;
         sel = $urandom_range(0, 9);
         if (sel < 8)       a = 32'($urandom_range(0, 15) * 4);
         else if (sel == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else               a = 32'(1024 + $urandom_range(0, 1000) * 4);
         op = $urandom_range(1, 3);
         rd = (op != 2);
         wr = (op != 1);
         d  = $urandom;
         b  = 4'($urandom_range(0, 15));
         isErr = ((a % 4) != 0) || (a >= 32'd1024);
         if (isErr)   expD = 32'h0;
         else if (rd) expD = model[int'(a / 4)];
         else         expD = lastData;
         if (wr && !isErr) begin
            for (int k = 0; k < 4; k++) begin
               if (b[k]) model[int'(a / 4)][8*k +: 8] = d[8*k +: 8];
            end
         end
         lastData = expD;
         applyStimulus(rd, wr, a, d, b, gd, ge, lat);
         checkOutput($sformatf("rand%0d_latency", n), 32'(lat), 32'd2);
         checkOutput($sformatf("rand%0d_data", n), gd, expD);
         checkOutput($sformatf("rand%0d_err", n), 32'(ge), 32'(isErr));
      end

      // A read held high continuously: each build must repeat IDLE/BUSY stall for
      // LATENCY cycles then one DONE cycle, never re-accepting in DONE.
      repeat (8) @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; addr = 32'h10;
      for (int i = 0; i < 20; i++) begin
         logic e1, e2, e4;
         #1;
         e1 = ((i % 2) == 1);
         e2 = ((i % 3) == 2);
         e4 = ((i % 5) == 4);
         checkOutput($sformatf("lat1_cycle%0d", i), {30'd0, ack1, stall1}, {30'd0, e1, !e1});
         checkOutput($sformatf("lat2_cycle%0d", i), {30'd0, ack2, stall2}, {30'd0, e2, !e2});
         checkOutput($sformatf("lat4_cycle%0d", i), {30'd0, ack4, stall4}, {30'd0, e4, !e4});
         @(negedge clk);
      end
      memread = 1'b0;
      repeat (6) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
